sng_decoder: RTL

- Stochastic-to-binary converter; the inverse of the SNG stage.
- Accepts one BITSTREAM-bit unipolar stochastic word per handshake and counts its ones over BITSTREAM/CHUNK cycles.
- Re-quantizes the count to a signed QUANT-bit value and presents it on a valid/ready output.
- Sits at the tail of the stochastic datapath, returning SC results to the binary domain. Beat framing (last) passes through.

---
 rtl/sng_decoder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sng_decoder.sv
// Stochastic-to-binary decoder: counts the ones of a unipolar bitstream CHUNK bits per cycle
// and re-quantizes the count to a signed QUANT-bit value. Optional Weyl phase check: SNG_DEC_PHASE_CHK_EN.
module sng_decoder #(
  parameter int BITSTREAM = 64,
  parameter int QUANT     = 8,
  parameter int CHUNK     = 16,
  parameter int BASE      = 2,
  parameter int STRIDE    = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BITSTREAM-1:0] s_bitstream,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  output logic [QUANT-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 m_err
);
  localparam int NCH   = BITSTREAM / CHUNK;
  localparam int LOG2B = $clog2(BITSTREAM);
  localparam int AW    = LOG2B + 1;
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int UW    = QUANT + AW;

  if ((STRIDE % 2) == 0 || (BITSTREAM % CHUNK) != 0 || BASE < 0 || (1 << QUANT) < BITSTREAM) begin : g_bad_cfg
    $error("sng_decoder: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, COUNT, CHK, OUT} state_t;

  state_t                r_state, w_state_nxt;
  logic [BITSTREAM-1:0]  r_bits;
  logic                  r_last;
  logic [AW-1:0]         r_acc, w_sum;
  logic [CW-1:0]         r_c;
  logic [CHUNK-1:0]      w_chunk;
  logic                  w_last_chunk;

  function automatic logic [AW-1:0] popcnt(input logic [CHUNK-1:0] v);
    logic [AW-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++) n = n + AW'(v[i]);
    return n;
  endfunction

  // Round-to-nearest rescale of 0..BITSTREAM onto 0..2^QUANT-1, then shift to signed by flipping the MSB.
  function automatic logic [QUANT-1:0] conv(input logic [AW-1:0] s);
    logic [UW-1:0] u;
    u = (({{QUANT{1'b0}}, s} << QUANT) + UW'(BITSTREAM / 2)) >> LOG2B;
    if (u > UW'((1 << QUANT) - 1)) u = UW'((1 << QUANT) - 1);
    return {~u[QUANT-1], u[QUANT-2:0]};
  endfunction

  assign w_chunk      = r_bits[r_c*CHUNK +: CHUNK];
  assign w_sum        = r_acc + popcnt(w_chunk);
  assign w_last_chunk = (r_c == CW'(NCH - 1));

`ifdef SNG_DEC_PHASE_CHK_EN
  logic [1:0]           r_phase, r_p;
  logic [BITSTREAM-1:0] w_mask;

  // Reference Weyl pattern for the final count; odd stride makes the positions distinct.
  always_comb begin
    w_mask = '0;
    for (int j = 0; j < BITSTREAM; j++)
      if (j < int'(r_acc)) w_mask[LOG2B'(BASE + int'(r_p) + j * STRIDE)] = 1'b1;
  end
`else
  assign m_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) w_state_nxt = COUNT;
      end
`ifdef SNG_DEC_PHASE_CHK_EN
      COUNT: if (w_last_chunk) w_state_nxt = CHK;
      CHK:   w_state_nxt = OUT;
`else
      COUNT: if (w_last_chunk) w_state_nxt = OUT;
`endif
      OUT:     if (m_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bits  <= '0;
      r_last  <= 1'b0;
      r_acc   <= '0;
      r_c     <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
`ifdef SNG_DEC_PHASE_CHK_EN
      m_err   <= 1'b0;
      r_phase <= 2'd0;
      r_p     <= 2'd0;
`endif
    end else begin
      case (r_state)
        IDLE: if (s_valid) begin
          r_bits  <= s_bitstream;
          r_last  <= s_last;
          r_acc   <= '0;
          r_c     <= '0;
`ifdef SNG_DEC_PHASE_CHK_EN
          r_p     <= r_phase;
          r_phase <= s_last ? 2'd0 : r_phase + 2'd1;
`endif
        end
        COUNT: begin
          r_acc <= w_sum;
          r_c   <= w_last_chunk ? '0 : r_c + CW'(1);
`ifndef SNG_DEC_PHASE_CHK_EN
          if (w_last_chunk) begin
            m_data  <= conv(w_sum);
            m_last  <= r_last;
            m_valid <= 1'b1;
          end
`endif
        end
`ifdef SNG_DEC_PHASE_CHK_EN
        CHK: begin
          m_data  <= conv(r_acc);
          m_last  <= r_last;
          m_err   <= (w_mask != r_bits);
          m_valid <= 1'b1;
        end
`endif
        OUT: if (m_ready) m_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
